// File: rtl/arrhythmia_infer_sched_if.sv
// Frame-in / result-out handshake bundle for arrhythmia_infer_sched.
//   in_valid/in_ready/in_x     : frame offer (sample 0 in MSBs)
//   res_valid/res_ready/res_*  : classification result and raw scores
// With ARR_SCHED_ACC_EN defined, in_label (ground truth) and res_match are added.
// Modports: master = frame source / result sink, slave = scheduler.
interface arrhythmia_infer_sched_if #(
    parameter int unsigned BITSIZE = 16,
    parameter int unsigned NSAMP   = 10
);
    logic                       in_valid;
    logic                       in_ready;
    logic [BITSIZE*NSAMP-1:0]   in_x;
    logic                       res_valid;
    logic                       res_ready;
    logic                       res_class;
    logic [BITSIZE-1:0]         res_y1;
    logic [BITSIZE-1:0]         res_y2;
    logic                       res_timeout;
`ifdef ARR_SCHED_ACC_EN
    logic                       in_label;
    logic                       res_match;
`endif

    modport master (
        output in_valid, in_x, res_ready,
        input  in_ready, res_valid, res_class, res_y1, res_y2, res_timeout
`ifdef ARR_SCHED_ACC_EN
        , output in_label
        , input  res_match
`endif
    );

    modport slave (
        input  in_valid, in_x, res_ready,
        output in_ready, res_valid, res_class, res_y1, res_y2, res_timeout
`ifdef ARR_SCHED_ACC_EN
        , input  in_label
        , output res_match
`endif
    );
endinterface

// File: rtl/arrhythmia_infer_sched.sv
// Sequencer around the arrhythmia inference core: accepts a frame, pulses the
// core reset, holds the frame on the core inputs, waits for done (with timeout),
// classifies {y1,y2} (class 1 iff y1 > y2, sign-magnitude) and returns the result.
// Ports:
//   clk, reset (async, active low)
//   bus         : frame/result handshake (slave modport)
//   core_reset  : active-high reset to the core, core_x: frame to the core
//   core_y      : {y1,y2} from the core, core_done: core done level
//   busy        : scheduler not idle
//   stat_*      : saturating counters of delivered results, class-1 results, timeouts
// Optional macro ARR_SCHED_ACC_EN adds in_label/res_match on bus and stat_correct.
module arrhythmia_infer_sched #(
    parameter int unsigned BITSIZE    = 16,
    parameter int unsigned NSAMP      = 10,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    arrhythmia_infer_sched_if.slave    bus,
    output logic                       core_reset,
    output logic [BITSIZE*NSAMP-1:0]   core_x,
    input  logic [2*BITSIZE-1:0]       core_y,
    input  logic                       core_done,
    output logic                       busy,
    output logic [CNT_W-1:0]           stat_frames,
    output logic [CNT_W-1:0]           stat_class1,
    output logic [CNT_W-1:0]           stat_tmo
`ifdef ARR_SCHED_ACC_EN
    , output logic [CNT_W-1:0]         stat_correct
`endif
);
    localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, CLR, RUN, CMP, OUT} state_t;

    state_t         state;
    logic [CW-1:0]  clr_cnt;
    logic [TW-1:0]  tmo_cnt;
`ifdef ARR_SCHED_ACC_EN
    logic           label;
`endif

    // Sign-magnitude a > b; +0 and -0 compare equal.
    function automatic logic sm_gt(input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] b);
        logic [BITSIZE-2:0] ma;
        logic [BITSIZE-2:0] mb;
        logic               an;
        logic               bn;
        ma = a[BITSIZE-2:0];
        mb = b[BITSIZE-2:0];
        an = a[BITSIZE-1] && (ma != '0);
        bn = b[BITSIZE-1] && (mb != '0);
        if (an != bn)
            sm_gt = bn;
        else if (!an)
            sm_gt = (ma > mb);
        else
            sm_gt = (ma < mb);
    endfunction

    // Saturating increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        sat_inc = (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            clr_cnt         <= '0;
            tmo_cnt         <= '0;
            core_reset      <= 1'b1;
            core_x          <= '0;
            busy            <= 1'b0;
            bus.in_ready    <= 1'b1;
            bus.res_valid   <= 1'b0;
            bus.res_class   <= 1'b0;
            bus.res_y1      <= '0;
            bus.res_y2      <= '0;
            bus.res_timeout <= 1'b0;
            stat_frames     <= '0;
            stat_class1     <= '0;
            stat_tmo        <= '0;
`ifdef ARR_SCHED_ACC_EN
            label           <= 1'b0;
            bus.res_match   <= 1'b0;
            stat_correct    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        core_x          <= bus.in_x;
`ifdef ARR_SCHED_ACC_EN
                        label           <= bus.in_label;
`endif
                        clr_cnt         <= '0;
                        bus.in_ready    <= 1'b0;
                        bus.res_timeout <= 1'b0;
                        busy            <= 1'b1;
                        state           <= CLR;
                    end
                end
                CLR: begin
                    if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
                        core_reset <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= RUN;
                    end else begin
                        clr_cnt <= clr_cnt + CW'(1);
                    end
                end
                RUN: begin
                    // tmo_cnt==0 marks the first RUN cycle, where done may be stale.
                    if ((tmo_cnt != '0) && core_done) begin
                        bus.res_y1 <= core_y[2*BITSIZE-1:BITSIZE];
                        bus.res_y2 <= core_y[BITSIZE-1:0];
                        state      <= CMP;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        bus.res_timeout <= 1'b1;
                        bus.res_y1      <= '0;
                        bus.res_y2      <= '0;
                        state           <= CMP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                CMP: begin
                    // Zeroed scores on timeout compare equal, forcing class 0.
                    bus.res_class <= sm_gt(bus.res_y1, bus.res_y2);
`ifdef ARR_SCHED_ACC_EN
                    bus.res_match <= !bus.res_timeout && (sm_gt(bus.res_y1, bus.res_y2) == label);
`endif
                    bus.res_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.res_ready) begin
                        stat_frames   <= sat_inc(stat_frames, 1'b1);
                        stat_class1   <= sat_inc(stat_class1, bus.res_class);
                        stat_tmo      <= sat_inc(stat_tmo, bus.res_timeout);
`ifdef ARR_SCHED_ACC_EN
                        stat_correct  <= sat_inc(stat_correct, bus.res_match);
`endif
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        core_reset    <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arrhythmia_infer_sched.sv
// Randomized self-checking bench for arrhythmia_infer_sched with a behavioural
// core model and a reference model of latency, classification and statistics.
module tb_arrhythmia_infer_sched;
    localparam int unsigned BS   = 16;
    localparam int unsigned NS   = 10;
    localparam int unsigned FW   = BS * NS;
    localparam int unsigned CLRC = 2;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CW   = 4;
    localparam int          SMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            core_reset;
    logic [FW-1:0]   core_x;
    logic [2*BS-1:0] core_y;
    logic            core_done;
    logic            busy;
    logic [CW-1:0]   stat_frames;
    logic [CW-1:0]   stat_class1;
    logic [CW-1:0]   stat_tmo;
`ifdef ARR_SCHED_ACC_EN
    logic [CW-1:0]   stat_correct;
    int              m_correct;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_frames, m_class1, m_tmo;

    always #5 clk = ~clk;

    arrhythmia_infer_sched_if #(.BITSIZE(BS), .NSAMP(NS)) bus ();

    arrhythmia_infer_sched #(
        .BITSIZE(BS), .NSAMP(NS), .CLR_CYCLES(CLRC), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .core_reset  (core_reset),
        .core_x      (core_x),
        .core_y      (core_y),
        .core_done   (core_done),
        .busy        (busy),
        .stat_frames (stat_frames),
        .stat_class1 (stat_class1),
        .stat_tmo    (stat_tmo)
`ifdef ARR_SCHED_ACC_EN
        , .stat_correct(stat_correct)
`endif
    );

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sm2int(input logic [BS-1:0] v);
        int m;
        m = int'(v[BS-2:0]);
        return v[BS-1] ? -m : m;
    endfunction

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic check_stats();
        check("stat_frames", FW'(stat_frames), FW'(m_frames));
        check("stat_class1", FW'(stat_class1), FW'(m_class1));
        check("stat_tmo",    FW'(stat_tmo),    FW'(m_tmo));
`ifdef ARR_SCHED_ACC_EN
        check("stat_correct", FW'(stat_correct), FW'(m_correct));
`endif
    endtask

    task automatic model_clear();
        m_frames = 0; m_class1 = 0; m_tmo = 0;
`ifdef ARR_SCHED_ACC_EN
        m_correct = 0;
`endif
    endtask

    task automatic check_reset_state();
        check("rst_in_ready",   FW'(bus.in_ready), FW'(1));
        check("rst_core_reset", FW'(core_reset), FW'(1));
        check("rst_core_x",     core_x, '0);
        check("rst_res",        FW'({bus.res_valid, bus.res_class, bus.res_timeout, bus.res_y1, bus.res_y2}), '0);
        check("rst_busy",       FW'(busy), '0);
        check_stats();
    endtask

    // One frame: core raises done d cycles after core_reset falls; result is held rd cycles.
    task automatic run_frame(input logic [BS-1:0] y1, input logic [BS-1:0] y2,
                             input int d, input int rd, input logic label);
        logic [FW-1:0] x;
        logic [35:0]   held;
        logic          exp_cls;
        logic          exp_to;
        int            lat, hi, rc, c, r_exp;
        for (int i = 0; i < int'(NS); i++) x[i*BS +: BS] = BS'($urandom);
        for (int i = 0; i < 50 && !bus.in_ready; i++) begin @(posedge clk); #1; end
        check("in_ready_idle", FW'(bus.in_ready), FW'(1));
        bus.in_valid = 1'b1;
        bus.in_x     = x;
`ifdef ARR_SCHED_ACC_EN
        bus.in_label = label;
`endif
        core_y = {y1, y2};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_x     = ~x;
        lat = 1;
        check("accept", FW'({bus.in_ready, busy, core_reset}), FW'(3'b011));
        check("core_x", core_x, x);
        hi = 0;
        while (core_reset && hi < 50) begin hi++; @(posedge clk); #1; lat++; end
        check("clr_cycles", FW'(hi), FW'(CLRC));
        rc = 0;
        while (!bus.res_valid && lat < 200) begin
            core_done = (rc >= d);
            @(posedge clk); #1;
            lat++; rc++;
        end
        c = (d < 1) ? 1 : d;
        exp_to = (c > int'(TMO) - 1);
        r_exp  = exp_to ? int'(TMO) : c + 1;
        exp_cls = exp_to ? 1'b0 : (sm2int(y1) > sm2int(y2));
        check("latency", FW'(lat), FW'(1 + CLRC + r_exp + 1));
        check("res_class",   FW'(bus.res_class), FW'(exp_cls));
        check("res_timeout", FW'(bus.res_timeout), FW'(exp_to));
        check("res_scores",  FW'({bus.res_y1, bus.res_y2}), exp_to ? '0 : FW'({y1, y2}));
`ifdef ARR_SCHED_ACC_EN
        check("res_match", FW'(bus.res_match), FW'(!exp_to && (exp_cls == label)));
`endif
        // Backpressure: a new frame is offered but must not be taken.
        held = {bus.res_valid, 1'b0, exp_cls, exp_to, (exp_to ? 32'h0 : {y1, y2})};
        bus.in_valid = 1'b1;
        for (int i = 0; i < rd; i++) begin
            @(posedge clk); #1;
            check("hold", FW'({bus.res_valid, bus.in_ready, bus.res_class, bus.res_timeout,
                              bus.res_y1, bus.res_y2}), FW'(held));
        end
        check("hold_core_x", core_x, x);
        check("hold_stats", FW'(stat_frames), FW'(m_frames));
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        m_frames = sat(m_frames + 1);
        if (exp_cls) m_class1 = sat(m_class1 + 1);
        if (exp_to)  m_tmo    = sat(m_tmo + 1);
`ifdef ARR_SCHED_ACC_EN
        if (!exp_to && exp_cls == label) m_correct = sat(m_correct + 1);
`endif
        check("handshake", FW'({bus.res_valid, bus.in_ready, core_reset, busy}), FW'(4'b0110));
        check_stats();
    endtask

    initial begin
        logic [BS-1:0] ry1, ry2;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.res_ready = 1'b0;
`ifdef ARR_SCHED_ACC_EN
        bus.in_label  = 1'b0;
`endif
        core_y    = '0;
        core_done = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state();

        run_frame(16'h0400, 16'h8200, 5, 0, 1'b1);
        run_frame(16'h8400, 16'h8200, 3, 0, 1'b0);
        run_frame(16'h8000, 16'h0000, 2, 1, 1'b0);
        run_frame(16'h0801, 16'h0800, 1, 0, 1'b1);
        run_frame(16'h0100, 16'h0200, 0, 0, 1'b0);
        run_frame(16'h1234, 16'h0001, 20, 0, 1'b0);
        run_frame(16'h0200, 16'h0100, int'(TMO) - 1, 0, 1'b1);
        run_frame(16'h0200, 16'h0100, int'(TMO), 0, 1'b1);
        run_frame(16'h0300, 16'h8300, 4, 20, 1'b1);

        for (int n = 0; n < 20; n++) begin
            ry1 = BS'($urandom);
            ry2 = ($urandom_range(0, 3) == 0) ? ry1 : BS'($urandom);
            run_frame(ry1, ry2, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        // Reset pulled during RUN aborts the frame and clears everything.
        core_done    = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (CLRC + 2) @(posedge clk);
        #1;
        check("mid_run_busy", FW'({busy, core_reset}), FW'(2'b10));
        reset = 1'b0;
        #1;
        model_clear();
        check_reset_state();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        run_frame(16'h0400, 16'h8200, 5, 0, 1'b1);
        check("post_rst_frames", FW'(stat_frames), FW'(1));

`ifdef ARR_SCHED_ACC_EN
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        run_frame(16'h0400, 16'h8200, 3, 0, 1'b1);
        run_frame(16'h0400, 16'h8200, 3, 0, 1'b0);
        run_frame(16'h8200, 16'h0400, 3, 0, 1'b0);
        check("acc_correct", FW'(stat_correct), FW'(2));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/arrhythmia_infer_sched.md
Name: arrhythmia_infer_sched

Overview:
Sequencer wrapped around the top_arrhythmia inference core.
- Accepts 10-sample ECG frames over a valid/ready handshake and gives the core a clean reset before each frame.
- Holds the frame stable on the core inputs, waits for the core's done flag (with timeout), then classifies the result: class 1 iff y1 > y2 in sign-magnitude Q4.11.
- Returns class plus raw scores on a valid/ready result port and keeps run statistics.

Parameters:
BITSIZE, 16, width of one sample and of each score (sign-magnitude: 1 sign, 4 integer, 11 fraction bits)
NSAMP, 10, samples per frame
CLR_CYCLES, 2, cycles the core reset is held high per frame (min 1)
TIMEOUT, 1023, maximum cycles in RUN waiting for core done (min 1)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  frame offered
in_ready  out  1  frame accepted when in_valid&&in_ready
in_x  in  BITSIZE*NSAMP  frame, sample 0 in MSBs
core_reset  out  1  active-high reset to the inference core
core_x  out  BITSIZE*NSAMP  frame driven to the core
core_y  in  2*BITSIZE  {y1,y2} from the core
core_done  in  1  core done flag (level)
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid&&res_ready
res_class  out  1  1 iff y1 > y2
res_y1  out  BITSIZE  latched y1
res_y2  out  BITSIZE  latched y2
res_timeout  out  1  result produced by timeout; class forced 0, scores 0
busy  out  1  state != IDLE
stat_frames  out  CNT_W  results delivered
stat_class1  out  CNT_W  results with class 1
stat_tmo  out  CNT_W  timeouts

Behaviour:
- Reset (reset low, async): state IDLE; in_ready=1; core_reset=1; core_x=0; res_*=0; busy=0; all counters 0.
- States: IDLE, CLR, RUN, CMP, OUT.
- IDLE: in_ready=1; core_reset=1.
  - On accept: latch in_x into frame register; go to CLR; clear the clear-counter.
  - in_ready is registered and drops the cycle after accept.
- CLR: core_reset=1; core_x=frame. After CLR_CYCLES cycles go to RUN with the timeout counter cleared.
- RUN: core_reset=0; core_x=frame.
  - First cycle of RUN: core_done is ignored, because it may be stale from the previous frame.
  - From the second RUN cycle on, core_done=1 captures core_y into res_y1/res_y2 and goes to CMP.
  - If the timeout counter reaches TIMEOUT without done: res_timeout=1, res_y1=res_y2=0, go to CMP.
  - If done and timeout coincide, done wins.
- CMP (1 cycle): res_class = y1 > y2 in sign-magnitude.
  - Signs differ: the positive value is larger.
  - Both positive: compare magnitudes.
  - Both negative: the smaller magnitude is larger.
  - +0 and -0 are equal; equal values give class 0.
  - Then go to OUT with res_valid=1.
- OUT: res_valid held with all res_* stable until res_ready.
  - On handshake: stat_frames+=1; stat_class1+=class; stat_tmo+=timeout.
  - Then res_valid=0 and go to IDLE.
  - core_reset is reasserted on IDLE entry.
- Counters saturate at all-ones; they do not wrap.
- Latency: accept to res_valid = 1 + CLR_CYCLES + RUN cycles + 1, measured in clock edges.
- res_ready while res_valid=0 is ignored. in_valid outside IDLE is ignored; the frame is not consumed.
- Reset asserted mid-frame aborts immediately into the reset state. No partial result is emitted and counters clear.

Optional Feature:
Macro ARR_SCHED_ACC_EN.
- Defined, these ports are added:
  - in_label  in  1  ground-truth class, latched with the frame
  - stat_correct  out  CNT_W  count of delivered, non-timeout results with res_class==label (saturating, reset 0)
  - res_match  out  1  valid with res_valid
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset low, then high; hold in_valid=0 → in_ready=1, core_reset=1, res_valid=0, all counters 0.
- CLR_CYCLES=2; frame accepted at cycle 0; model core asserts done 5 cycles after core_reset falls with y1=16'h0400 (+0.5), y2=16'h8200 (-0.25):
  - core_reset high for exactly 2 cycles.
  - res_valid rises with class=1.
  - With res_ready=1: stat_frames=1, stat_class1=1.
- Score cases:
  - y1=16'h8400, y2=16'h8200 → class 0.
  - y1=16'h8000, y2=16'h0000 → class 0.
  - y1=16'h0801, y2=16'h0800 → class 1.
- Timeout: TIMEOUT=8, core never asserts done → result after 8 RUN cycles with res_timeout=1, class 0, scores 0, stat_tmo=1.
- Backpressure: res_ready=0 for 20 cycles while in_valid=1 → res_* stable, in_ready=0, no second accept. After res_ready: counters increment once, then the next frame is accepted.
- Reset pulled low during RUN → all outputs return to reset values within the same cycle. After release, a new frame completes normally with stat_frames=1.
- With ARR_SCHED_ACC_EN: 3 frames, labels {1,0,0}, predictions {1,1,0} → stat_correct=2.
